// File: rtl/ftdi_pkg.sv
// Shared constants and state encodings for the FT245-style synchronous FIFO interface.
package ftdi_pkg;
  localparam int FT_BYTE_W        = 8;
  localparam int FT_RX_DEPTH_LOG2 = 9;
  localparam int FT_TX_DEPTH_LOG2 = 9;
  localparam int FT_RX_AF_MARGIN  = 2;
  localparam int FT_TX_AE_LEVEL   = 1;
  localparam int FT_TX_PRIO_LEVEL = 256;

  typedef enum logic [1:0] {
    FT_ST_IDLE   = 2'd0,
    FT_ST_OUT_EN = 2'd1,
    FT_ST_READ   = 2'd2,
    FT_ST_WRITE  = 2'd3
  } ftdi_state_e;
endpackage

// File: rtl/ftdi_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; head reads as zero while empty.
module ftdi_sync_fifo #(
  parameter int W  = 8,
  parameter int DL = 9
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [DL:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << DL;
  localparam int CW    = DL + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [DL-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok, w_pop_ok;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk)
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + DL'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + DL'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/ftdi_interface_datapath.sv
// FTDI byte datapath: RX/TX FIFOs, bus direction and status flags for the control FSM.
module ftdi_interface_datapath
  import ftdi_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = FT_RX_DEPTH_LOG2,
  parameter int TX_DEPTH_LOG2 = FT_TX_DEPTH_LOG2,
  parameter int RX_AF_MARGIN  = FT_RX_AF_MARGIN,
  parameter int TX_AE_LEVEL   = FT_TX_AE_LEVEL,
  parameter int TX_PRIO_LEVEL = FT_TX_PRIO_LEVEL
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 rxf_n,
  input  logic                 txe_n,
  input  logic                 rd_n,
  input  logic                 oe_n,
  input  logic                 wr_n,
  input  logic [FT_BYTE_W-1:0] ft_data_in,
  output logic [FT_BYTE_W-1:0] ft_data_out,
  output logic                 ft_data_oe,
  output logic                 rf_almost_full,
  output logic                 wf_almost_empty,
  output logic                 wf_empty,
  output logic                 prio,
  output logic [FT_BYTE_W-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [FT_BYTE_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 rx_overflow,
  output logic                 tx_underrun
);
  localparam int RX_AF_CNT = (1 << RX_DEPTH_LOG2) - RX_AF_MARGIN;

  logic [RX_DEPTH_LOG2:0] w_rx_count;
  logic [TX_DEPTH_LOG2:0] w_tx_count;
  logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic r_rx_overflow, r_tx_underrun;

  assign w_rx_push = ~rd_n & ~rxf_n;
  assign w_rx_pop  = rx_valid & rx_ready;
  assign w_tx_push = tx_valid & tx_ready;
  assign w_tx_pop  = ~wr_n & ~txe_n;

  ftdi_sync_fifo #(.W(FT_BYTE_W), .DL(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .res_n(res_n),
    .i_push(w_rx_push), .i_din(ft_data_in), .i_pop(w_rx_pop),
    .o_dout(rx_data), .o_count(w_rx_count), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  ftdi_sync_fifo #(.W(FT_BYTE_W), .DL(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .res_n(res_n),
    .i_push(w_tx_push), .i_din(tx_data), .i_pop(w_tx_pop),
    .o_dout(ft_data_out), .o_count(w_tx_count), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_rx_overflow <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      if (w_rx_push & w_rx_full & ~w_rx_pop) r_rx_overflow <= 1'b1;
      if (w_tx_pop & w_tx_empty)              r_tx_underrun <= 1'b1;
    end
  end

  assign rx_valid        = ~w_rx_empty;
  assign tx_ready        = ~w_tx_full;
  assign ft_data_oe      = oe_n;
  assign wf_empty        = w_tx_empty;
  assign wf_almost_empty = int'(w_tx_count) <= TX_AE_LEVEL;
  assign prio            = int'(w_tx_count) >= TX_PRIO_LEVEL;
  assign rf_almost_full  = int'(w_rx_count) >= RX_AF_CNT;
  assign rx_overflow     = r_rx_overflow;
  assign tx_underrun     = r_tx_underrun;
endmodule

// File: doc/ftdi_interface_datapath.md
Name: ftdi_interface_datapath

Overview:
Byte datapath for the FT245-style synchronous FIFO interface. It owns one receive FIFO (FTDI -> FPGA) and one transmit FIFO (FPGA -> FTDI), and handles the FTDI data bus. It generates the status inputs consumed by ftdi_interface_control_fsm (rf_almost_full, wf_almost_empty, wf_empty, prio). It acts on that FSM's registered strobes (rd_n, oe_n, wr_n) to push received bytes and pop transmitted bytes.

Parameters:
RX_DEPTH_LOG2, 9, log2 of RX FIFO depth (512 bytes)
TX_DEPTH_LOG2, 9, log2 of TX FIFO depth
RX_AF_MARGIN, 2, rf_almost_full asserts when free RX slots <= this value
TX_AE_LEVEL, 1, wf_almost_empty asserts when TX count <= this value
TX_PRIO_LEVEL, 256, prio asserts when TX count >= this value

Ports:
clk  in  1  interface clock (FTDI 60 MHz CLKOUT domain)
res_n  in  1  asynchronous active-low reset
rxf_n  in  1  FTDI: RX data available (active low)
txe_n  in  1  FTDI: TX space available (active low)
rd_n  in  1  from control FSM
oe_n  in  1  from control FSM
wr_n  in  1  from control FSM
ft_data_in  in  8  FTDI data bus, input side of pad
ft_data_out  out  8  FTDI data bus, output side of pad
ft_data_oe  out  1  pad output enable, 1 = FPGA drives bus
rf_almost_full  out  1  to FSM
wf_almost_empty  out  1  to FSM
wf_empty  out  1  to FSM
prio  out  1  to FSM: TX backlog high, favour writing
rx_data  out  8  user RX byte (head of RX FIFO)
rx_valid  out  1  RX FIFO non-empty
rx_ready  in  1  user accepts rx_data
tx_data  in  8  user TX byte
tx_valid  in  1  user offers tx_data
tx_ready  out  1  TX FIFO not full
rx_overflow  out  1  sticky: byte arrived with RX FIFO full
tx_underrun  out  1  sticky: FTDI write strobe with TX FIFO empty

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low on res_n.
- Reset values:
  - Both FIFOs empty, pointers 0.
  - rx_valid=0, tx_ready=1.
  - wf_empty=1, wf_almost_empty=1, rf_almost_full=0, prio=0.
  - rx_overflow=0, tx_underrun=0.
  - ft_data_out=head register=8'h00.
  - Reset asserted mid-transfer empties both FIFOs immediately; in-flight bytes are discarded.
- RX push: on a rising edge with rd_n=0 and rxf_n=0, ft_data_in is written to the RX FIFO.
  - If the RX FIFO is full, the byte is dropped and rx_overflow is set.
- TX pop: on a rising edge with wr_n=0 and txe_n=0, the FTDI captures ft_data_out and the TX FIFO pops.
  - If the TX FIFO is empty, there is no pop and tx_underrun is set.
  - wr_n=0 with txe_n=1: no pop; ft_data_out holds the same byte for retry.
- FIFO type: both FIFOs are first-word-fall-through.
  - ft_data_out = TX head; rx_data = RX head.
  - A head change is visible in the cycle after the pop.
  - A byte written into an empty FIFO is visible at the head one cycle after the push edge.
- User side:
  - RX pops when rx_valid & rx_ready.
  - TX pushes when tx_valid & tx_ready; tx_ready = !tx_full.
  - Simultaneous push and pop on the same FIFO leaves count unchanged and both operations take effect. This holds even when the FIFO is full (pop frees the slot) and when it is empty (push only; the pop is ignored since valid=0).
- Status flags: combinational from the registered counts.
  - wf_empty = (tx_count==0)
  - wf_almost_empty = (tx_count<=TX_AE_LEVEL)
  - prio = (tx_count>=TX_PRIO_LEVEL)
  - rf_almost_full = (RX free <= RX_AF_MARGIN)
- Margin rationale: the FSM reacts one cycle late, so one extra RX push after rf_almost_full is legal. With margin 2, no overflow occurs in normal operation.
- Bus direction: ft_data_oe = oe_n. The FPGA releases the bus whenever the FSM has granted FTDI drive (oe_n=0). rd_n=0 implies oe_n=0.
- Counters:
  - Counts are DEPTH_LOG2+1 bits wide.
  - Pointers are DEPTH_LOG2 bits wide and wrap naturally modulo depth.
- Sticky flags clear only on reset.

Decomposition:
- Package ftdi_pkg:
  - FT_BYTE_W=8
  - default depth and threshold constants
  - FSM state encodings (idle, out_en, read, write) shared with the control FSM
- One sub-module: ftdi_sync_fifo, a parameterised FWFT FIFO with count output, full, empty and single-clock async-low reset. It is instantiated twice.
- Threshold compare logic stays in ftdi_interface_datapath.

Test Plan:
- RX burst: hold rxf_n=0, rd_n=0, oe_n=0 and drive bytes 0x00..0x0F over 16 edges, with rx_ready=1 -> rx_data yields 0x00..0x0F in order; rx_overflow=0; ft_data_oe=0 throughout.
- TX drain with retry: push 0xA1, 0xA2, 0xA3; hold wr_n=0; txe_n pattern 0,1,0,0 -> ft_data_out sequence A1, A2, A2, A3; three pops; then wf_empty=1. wf_almost_empty=1 from the cycle when count is 1.
- RX near-full: RX_DEPTH_LOG2=4, rx_ready=0, push 14 bytes -> rf_almost_full=1 at count 14. Two more pushes land (count 16, rx_overflow=0); a 17th push sets rx_overflow=1 and the byte is dropped.
- prio threshold: with TX_PRIO_LEVEL=4, push 3 bytes -> prio=0; a 4th -> prio=1. Simultaneous user push and FTDI pop at count 4 -> count stays 4 and prio stays 1.
- Underrun: empty TX FIFO, wr_n=0, txe_n=0 for one edge -> tx_underrun=1, count stays 0, wf_empty=1.
- Reset mid-transfer: 5 bytes in each FIFO, res_n low for 1 ns between edges -> immediately rx_valid=0, wf_empty=1, tx_ready=1, flags 0; after release, a new push is read back correctly.
